// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU operation encodings
package alu_arbiter_pkg;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_SLT   = 4'd9,
    ALU_SLTU  = 4'd10,
    ALU_PASSB = 4'd11
  } alu_op_e;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: 32-bit combinational ALU; unassigned opcodes yield zero
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] out_o
);
  always_comb begin
    out_o = '0;
    case (op_i)
      ALU_ADD:   out_o = a_i + b_i;
      ALU_SUB:   out_o = a_i - b_i;
      ALU_AND:   out_o = a_i & b_i;
      ALU_OR:    out_o = a_i | b_i;
      ALU_XOR:   out_o = a_i ^ b_i;
      ALU_NOR:   out_o = ~(a_i | b_i);
      ALU_SLL:   out_o = a_i << b_i[4:0];
      ALU_SRL:   out_o = a_i >> b_i[4:0];
      ALU_SRA:   out_o = $signed(a_i) >>> b_i[4:0];
      ALU_SLT:   out_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  out_o = {31'd0, a_i < b_i};
      ALU_PASSB: out_o = b_i;
      default:   out_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter with bounded lock in front of one ALU and a result register
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [3:0]  req0_ALUop,
  input  logic [3:0]  req1_ALUop,
  input  logic        req0_lock,
  input  logic        req1_lock,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_Out
);
  localparam logic [2:0] LOCK_LIMIT = 3'd4;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;
  state_e      state_q;
  logic        owner_q, last_q, resp_valid_q, resp_id_q;
  logic [2:0]  cnt_q;
  logic [31:0] resp_out_q, alu_out;
  logic        room, g0, g1, acc, sel, sel_lock, owner_valid;
  always_comb begin
    room = !reset && (!resp_valid_q || resp_ready);
    g0 = state_q == LOCKED ? !owner_q && req0_valid : req0_valid && (!req1_valid || last_q);
    g1 = state_q == LOCKED ? owner_q && req1_valid : req1_valid && (!req0_valid || !last_q);
  end
  assign req0_ready  = g0 && room;
  assign req1_ready  = g1 && room;
  assign acc         = req0_ready || req1_ready;
  assign sel         = req1_ready;
  assign sel_lock    = sel ? req1_lock : req0_lock;
  assign owner_valid = owner_q ? req1_valid : req0_valid;
  alu_arbiter_alu u_alu (
    .a_i  (sel ? req1_A : req0_A),
    .b_i  (sel ? req1_B : req0_B),
    .op_i (sel ? req1_ALUop : req0_ALUop),
    .out_o(alu_out)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= UNLOCKED;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_out_q   <= '0;
    end else begin
      if (acc) begin
        resp_valid_q <= 1'b1;
        resp_id_q    <= sel;
        resp_out_q   <= alu_out;
        last_q       <= sel;
      end else if (resp_ready) begin
        resp_valid_q <= 1'b0;
      end
      if (state_q == UNLOCKED) begin
        if (acc && sel_lock) begin
          state_q <= LOCKED;
          owner_q <= sel;
          cnt_q   <= 3'd1;
        end
      end else if (acc && sel_lock && cnt_q < LOCK_LIMIT - 3'd1) begin
        cnt_q <= cnt_q + 3'd1;
      end else if (acc || (!owner_valid && room)) begin
        // owner finished, hit the limit, or idled while it could have issued
        state_q <= UNLOCKED;
        cnt_q   <= '0;
      end
    end
  end
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_Out   = resp_out_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus random traffic checked against a transaction-level model
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_A = 0, req0_B = 0, req1_A = 0, req1_B = 0;
  logic [3:0]  req0_ALUop = 0, req1_ALUop = 0;
  logic        req0_lock = 0, req1_lock = 0;
  logic        resp_valid, resp_ready = 1'b1, resp_id;
  logic [31:0] resp_Out;
  int errors = 0, checks = 0;
  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req1_A(req1_A), .req1_B(req1_B),
    .req0_ALUop(req0_ALUop), .req1_ALUop(req1_ALUop),
    .req0_lock(req0_lock), .req1_lock(req1_lock),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_Out(resp_Out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_NOR:   return ~(a | b);
      ALU_SLL:   return a << s;
      ALU_SRL:   return a >> s;
      ALU_SRA:   return $unsigned($signed(a) >>> s);
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_PASSB: return b;
      default:   return 32'd0;
    endcase
  endfunction
  typedef struct {logic id; logic [31:0] out;} res_t;
  res_t q[$];
  bit   started = 0, m_locked = 0, m_owner = 0, m_last = 1, room, n, lk;
  int   m_cnt = 0, want;
  // Inputs only change just after a rising edge, so the values seen at the
  // falling edge are exactly what the next rising edge will act on.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("resp_valid", resp_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("resp_id", resp_id, q[0].id);
        chk("resp_Out", resp_Out, q[0].out);
      end
      room = !reset && (q.size() == 0 || resp_ready);
      want = -1;
      if (req0_valid && req1_valid) want = m_last ? 0 : 1;
      else if (req0_valid) want = 0;
      else if (req1_valid) want = 1;
      if (m_locked) want = (m_owner ? req1_valid : req0_valid) ? int'(m_owner) : -1;
      if (!room) want = -1;
      chk("accept0", req0_valid && req0_ready, want == 0);
      chk("accept1", req1_valid && req1_ready, want == 1);
      chk("one_grant", req0_ready && req1_ready, 0);
    end
    if (reset) begin
      q.delete();
      m_locked = 0; m_owner = 0; m_cnt = 0; m_last = 1; started = 1;
    end else if (started) begin
      if (q.size() != 0 && resp_ready) void'(q.pop_front());
      if (want >= 0) begin
        n  = (want == 1);
        lk = n ? req1_lock : req0_lock;
        q.push_back('{id: n, out: n ? ref_alu(req1_ALUop, req1_A, req1_B) : ref_alu(req0_ALUop, req0_A, req0_B)});
        m_last = n;
        if (!m_locked) begin
          if (lk) begin m_locked = 1; m_owner = n; m_cnt = 1; end
        end else if (!lk) m_locked = 0;
        else begin
          m_cnt++;
          if (m_cnt == 4) m_locked = 0;
        end
      end else if (m_locked && !(m_owner ? req1_valid : req0_valid) && room) begin
        m_locked = 0;
      end
    end
  end
  logic [4:0] rec0, rec1;
  initial begin
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_out", resp_Out, 0);
    chk("rst_id", resp_id, 0);
    req0_valid = 1; req0_A = 5; req0_B = 7; req0_ALUop = ALU_ADD;
    req1_valid = 1; req1_A = 1; req1_B = 2; req1_ALUop = ALU_ADD;
    #1;
    chk("tie_g0", req0_ready, 1);
    chk("tie_w1", req1_ready, 0);
    step(); #1;
    chk("tie_out0", resp_Out, 12);
    chk("tie_id0", resp_id, 0);
    chk("tie_g1", req1_ready, 1);
    step(); #1;
    chk("tie_out1", resp_Out, 3);
    chk("tie_id1", resp_id, 1);
    req0_lock = 1;
    #1;
    for (int i = 0; i < 5; i++) begin
      rec0[i] = req0_ready;
      rec1[i] = req1_ready;
      step(); #1;
    end
    chk("lock_seq0", {27'd0, rec0}, 32'h0f);
    chk("lock_seq1", {27'd0, rec1}, 32'h10);
    req0_valid = 0; req1_valid = 0; req0_lock = 0;
    step(); #1;
    req0_valid = 1; req0_A = 10;  req0_B = 20; req0_ALUop = ALU_ADD;
    req1_valid = 1; req1_A = 100; req1_B = 1;  req1_ALUop = ALU_SUB;
    #1;
    chk("bp_g0", req0_ready, 1);
    step();
    resp_ready = 0;
    #1;
    chk("bp_out0", resp_Out, 30);
    for (int i = 0; i < 3; i++) begin
      chk("bp_nogrant", req0_ready | req1_ready, 0);
      chk("bp_hold", resp_Out, 30);
      step(); #1;
    end
    resp_ready = 1;
    #1;
    chk("bp_g1", req1_ready, 1);
    step(); #1;
    chk("bp_new", resp_Out, 99);
    chk("bp_newid", resp_id, 1);
    req0_valid = 0; req1_valid = 0;
    step(); #1;
    req1_valid = 1; req1_lock = 1; req1_A = 3; req1_B = 4; req1_ALUop = ALU_ADD;
    #1;
    chk("eu_g1a", req1_ready, 1);
    step();
    req1_lock = 0;
    req0_valid = 1; req0_lock = 0; req0_A = 6; req0_B = 7; req0_ALUop = ALU_XOR;
    #1;
    chk("eu_wait0", req0_ready, 0);
    chk("eu_g1b", req1_ready, 1);
    step(); #1;
    chk("eu_tie", req0_ready, 1);
    resp_ready = 0;
    step(); #1;
    chk("ms_pending", resp_valid, 1);
    reset = 1;
    #1;
    chk("ms_nogrant", req0_ready | req1_ready, 0);
    step();
    reset = 0;
    #1;
    chk("ms_cleared", resp_valid, 0);
    chk("ms_tie", req0_ready, 1);
    resp_ready = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      reset      = ($urandom_range(0, 59) == 0);
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_lock  = ($urandom_range(0, 2) == 0);
      req1_lock  = ($urandom_range(0, 2) == 0);
      req0_ALUop = 4'($urandom_range(0, 15));
      req1_ALUop = 4'($urandom_range(0, 15));
      req0_A = $urandom; req0_B = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
      req1_A = $urandom; req1_B = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    reset = 0; req0_valid = 0; req1_valid = 0; resp_ready = 1;
    repeat (3) step();
    #1;
    chk("drain_empty", resp_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
